// File: rtl/can_reg_pkg.sv
// can_reg_pkg: CAN register indices and default bank masks for a 32 x 8 register file.
package can_reg_pkg;
  localparam int CAN_WIDTH = 8;
  localparam int CAN_DEPTH = 32;
  localparam int CAN_BITS = CAN_WIDTH * CAN_DEPTH;
  typedef enum logic [4:0] {
    MODE   = 5'd0,
    CMD    = 5'd1,
    STATUS = 5'd2,
    IR     = 5'd3
  } can_reg_e;
  localparam logic [CAN_BITS-1:0] CAN_RST_VAL = CAN_BITS'(24'h0C_00_01);
  localparam logic [CAN_BITS-1:0] CAN_WR_MASK = ~(CAN_BITS'(16'hFFFF) << (STATUS * CAN_WIDTH));
  localparam logic [CAN_BITS-1:0] CAN_SET_MASK = CAN_BITS'(8'hFF) << (IR * CAN_WIDTH);
  localparam logic [CAN_BITS-1:0] CAN_COR_MASK = CAN_BITS'(8'hFF) << (IR * CAN_WIDTH);
endpackage

// File: rtl/can_reg_cell.sv
// can_reg_cell: one register with mask-gated write, sticky hardware set and clear-on-read.
module can_reg_cell
  import can_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] WR_MASK = '1,
  parameter logic [WIDTH-1:0] SET_MASK = '0,
  parameter logic [WIDTH-1:0] COR_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] hw_set,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] held, set_bits, nxt;
  logic en;
  // per-bit priority: hw set > writable write > clear-on-read > hold
  always_comb begin
    held = re ? (q & ~COR_MASK) : q;
    set_bits = hw_set & SET_MASK;
    nxt = set_bits | (we ? ((wr_data & WR_MASK) | (held & ~WR_MASK)) : held);
    en = we | re | (|set_bits);
  end
  always_ff @(posedge clk)
    if (rst) q <= RST_VAL;
    else if (en) q <= nxt;
endmodule

// File: rtl/can_register_bank.sv
// can_register_bank: CAN register file with decoded writes, registered reads and parallel export.
module can_register_bank
  import can_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW = 5,
  parameter int U_DLY = 1,
  parameter logic [DEPTH*WIDTH-1:0] RST_VAL = {DEPTH*WIDTH{1'b0}},
  parameter logic [DEPTH*WIDTH-1:0] WR_MASK = {DEPTH*WIDTH{1'b1}},
  parameter logic [DEPTH*WIDTH-1:0] SET_MASK = {DEPTH*WIDTH{1'b0}},
  parameter logic [DEPTH*WIDTH-1:0] COR_MASK = {DEPTH*WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   addr_err,
  input  logic [DEPTH*WIDTH-1:0] hw_set,
  output logic [DEPTH*WIDTH-1:0] regs_out
);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
  // U_DLY is only range-checked: the flops carry no simulation delay
  if (2**AW < DEPTH || U_DLY < 0) begin : g_bad_cfg
    $error("can_register_bank: AW too small for DEPTH or negative U_DLY");
  end
  logic [WIDTH-1:0] rd_mux;
  logic wr_ok, rd_ok;
  assign wr_ok = {1'b0, wr_addr} < LIM;
  assign rd_ok = {1'b0, rd_addr} < LIM;
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    can_reg_cell #(
      .WIDTH(WIDTH),
      .RST_VAL(RST_VAL[i*WIDTH +: WIDTH]),
      .WR_MASK(WR_MASK[i*WIDTH +: WIDTH]),
      .SET_MASK(SET_MASK[i*WIDTH +: WIDTH]),
      .COR_MASK(COR_MASK[i*WIDTH +: WIDTH])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .we(wr_en && wr_addr == AW'(i)),
      .re(rd_en && rd_addr == AW'(i)),
      .wr_data(wr_data),
      .hw_set(hw_set[i*WIDTH +: WIDTH]),
      .q(regs_out[i*WIDTH +: WIDTH])
    );
  end
  // out-of-range addresses match no entry and read back as zero
  always_comb begin
    rd_mux = '0;
    for (int j = 0; j < DEPTH; j++) rd_mux = (rd_addr == AW'(j)) ? regs_out[j*WIDTH +: WIDTH] : rd_mux;
  end
  always_ff @(posedge clk)
    if (rst) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (rd_en) rd_data <= rd_mux;
      rd_valid <= rd_en;
      addr_err <= (wr_en && !wr_ok) || (rd_en && !rd_ok);
    end
endmodule

// File: tb/tb_can_register_bank.sv
// tb_can_register_bank: directed scenario checks of the CAN register bank.
module tb_can_register_bank;
  import can_reg_pkg::*;
  localparam int W = 8;
  localparam int D = 32;
  localparam int A = 6;
  localparam int N = W * D;
  localparam logic [N-1:0] T_RST = N'(8'hA5);
  localparam logic [N-1:0] T_WR = ~(N'(8'hF0) << 8);
  localparam logic [N-1:0] T_SET = N'(8'h01) << (IR * W);
  localparam logic [N-1:0] T_COR = N'(8'h01) << (IR * W);
  logic clk = 1'b0;
  logic rst, wr_en, rd_en, rd_valid, addr_err;
  logic [A-1:0] wr_addr, rd_addr;
  logic [W-1:0] wr_data, rd_data;
  logic [N-1:0] hw_set, regs_out, exp_regs;
  int checks = 0;
  int errors = 0;
  can_register_bank #(
    .WIDTH(W), .DEPTH(D), .AW(A), .U_DLY(1),
    .RST_VAL(T_RST), .WR_MASK(T_WR), .SET_MASK(T_SET), .COR_MASK(T_COR)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .addr_err(addr_err), .hw_set(hw_set), .regs_out(regs_out)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; hw_set = '0;
    cyc();
    cyc();
    chk("reset_reg0", N'(regs_out[7:0]), N'(8'hA5));
    chk("reset_regs", regs_out, T_RST);
    chk("reset_rd_data", N'(rd_data), '0);
    chk("reset_rd_valid", N'(rd_valid), '0);
    chk("reset_addr_err", N'(addr_err), '0);
    rst = 1'b0;
  endtask
  task automatic test_masked_write();
    wr_en = 1'b1; wr_addr = 6'd1; wr_data = 8'hFF;
    cyc();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 6'd1;
    cyc();
    rd_en = 1'b0;
    chk("mw_rd_data", N'(rd_data), N'(8'h0F));
    chk("mw_rd_valid", N'(rd_valid), N'(1'b1));
    chk("mw_reg1", N'(regs_out[15:8]), N'(8'h0F));
    cyc();
    chk("mw_valid_pulse", N'(rd_valid), '0);
    chk("mw_rd_hold", N'(rd_data), N'(8'h0F));
  endtask
  task automatic test_sticky();
    hw_set[24] = 1'b1;
    cyc();
    hw_set = '0;
    chk("st_set", N'(regs_out[31:24]), N'(8'h01));
    rd_en = 1'b1; rd_addr = 6'(IR);
    cyc();
    chk("st_read1", N'(rd_data), N'(8'h01));
    chk("st_cleared", N'(regs_out[31:24]), '0);
    cyc();
    rd_en = 1'b0;
    chk("st_read2", N'(rd_data), '0);
  endtask
  task automatic test_set_race();
    hw_set[24] = 1'b1;
    cyc();
    rd_en = 1'b1; rd_addr = 6'(IR);
    cyc();
    hw_set = '0;
    chk("race_rd", N'(rd_data), N'(8'h01));
    chk("race_kept", N'(regs_out[31:24]), N'(8'h01));
    cyc();
    rd_en = 1'b0;
    chk("race_rd2", N'(rd_data), N'(8'h01));
  endtask
  task automatic test_collision();
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h11;
    cyc();
    wr_data = 8'h22; rd_en = 1'b1; rd_addr = 6'd5;
    cyc();
    wr_en = 1'b0;
    chk("col_old", N'(rd_data), N'(8'h11));
    chk("col_reg5", N'(regs_out[47:40]), N'(8'h22));
    cyc();
    rd_en = 1'b0;
    chk("col_new", N'(rd_data), N'(8'h22));
  endtask
  task automatic test_addr_err();
    exp_regs = '0;
    exp_regs[7:0] = 8'hA5;
    exp_regs[15:8] = 8'h0F;
    exp_regs[47:40] = 8'h22;
    wr_en = 1'b1; wr_addr = 6'd40; wr_data = 8'h77;
    cyc();
    wr_en = 1'b0;
    chk("ae_wr_err", N'(addr_err), N'(1'b1));
    chk("ae_wr_rdvalid", N'(rd_valid), '0);
    chk("ae_regs", regs_out, exp_regs);
    cyc();
    chk("ae_pulse", N'(addr_err), '0);
    rd_en = 1'b1; rd_addr = 6'd40;
    cyc();
    rd_en = 1'b0;
    chk("ae_rd_data", N'(rd_data), '0);
    chk("ae_rd_valid", N'(rd_valid), N'(1'b1));
    chk("ae_rd_err", N'(addr_err), N'(1'b1));
    wr_en = 1'b1; wr_addr = 6'd63; rd_en = 1'b1; rd_addr = 6'd41;
    cyc();
    wr_en = 1'b0; rd_addr = 6'd31;
    chk("ae_both_err", N'(addr_err), N'(1'b1));
    chk("ae_both_regs", regs_out, exp_regs);
    cyc();
    rd_en = 1'b0;
    chk("ae_inrange_err", N'(addr_err), '0);
    chk("ae_inrange_valid", N'(rd_valid), N'(1'b1));
  endtask
  task automatic test_mid_reset();
    wr_en = 1'b1; wr_addr = 6'd2; wr_data = 8'h5A; rd_en = 1'b1; rd_addr = 6'd5; hw_set = T_SET; rst = 1'b1;
    cyc();
    chk("mr_regs", regs_out, T_RST);
    chk("mr_rd_data", N'(rd_data), '0);
    chk("mr_rd_valid", N'(rd_valid), '0);
    chk("mr_addr_err", N'(addr_err), '0);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; hw_set = '0;
  endtask
  initial begin
    test_reset();
    test_masked_write();
    test_sticky();
    test_set_race();
    test_collision();
    test_addr_err();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
